add_stream_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one a+b stream adder among NUM_CH input channel pairs.
//  - Each channel is a pair of FWFT FIFOs (a, b). Output goes to one result FIFO, tagged with the source channel.
//  - Sits between the per-channel stream FIFOs and the downstream result FIFO.
//  - ap_start begins a job of ap_len beats. ap_done and ap_continue close the job.

---
 rtl/add_stream_rr_sched.sv | 144 ++++++++++++++
 tb/tb_add_stream_rr_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/add_stream_rr_sched.sv
// Round-robin scheduler sharing one a+b stream adder among NUM_CH FWFT FIFO channel pairs.
// Optional per-channel beat counters are enabled by defining ADD_STREAM_RR_SCHED_STATS_EN.
module add_stream_rr_sched #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [NUM_CH*DATA_W-1:0]   a_dout,
    input  logic [NUM_CH-1:0]          a_empty_n,
    output logic [NUM_CH-1:0]          a_read,
    input  logic [NUM_CH*DATA_W-1:0]   b_dout,
    input  logic [NUM_CH-1:0]          b_empty_n,
    output logic [NUM_CH-1:0]          b_read,
    output logic [DATA_W-1:0]          c_din,
    output logic [$clog2(NUM_CH)-1:0]  c_ch,
    input  logic                       c_full_n,
    output logic                       c_write,
`ifdef ADD_STREAM_RR_SCHED_STATS_EN
    input  logic [$clog2(NUM_CH)-1:0]  stat_sel,
    output logic [31:0]                stat_cnt,
`endif
    input  logic                       ap_start,
    input  logic [LEN_W-1:0]           ap_len,
    output logic                       ap_idle,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic                       ap_continue
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [LEN_W-1:0]  remaining;
    logic              out_valid;

    logic [NUM_CH-1:0] elig;
    logic              any_elig;
    logic [CH_W-1:0]   grant;
    logic              issue;
    int                idx;

    assign elig     = a_empty_n & b_empty_n;
    assign any_elig = |elig;
    assign c_write  = out_valid && c_full_n;
    assign issue    = (state == RUN) && (remaining != '0) && any_elig && (!out_valid || c_full_n);

    // Search downward from the farthest offset so the nearest eligible channel at or after rr_ptr wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (elig[idx]) grant = CH_W'(idx);
        end
    end

    // a and b of the granted channel are always popped together, never one alone.
    always_comb begin
        a_read = '0;
        b_read = '0;
        if (issue) begin
            a_read[grant] = 1'b1;
            b_read[grant] = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            c_din     <= '0;
            c_ch      <= '0;
            ap_idle   <= 1'b1;
            ap_ready  <= 1'b0;
            ap_done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ap_ready <= 1'b0;

            if (issue) begin
                c_din     <= a_dout[grant*DATA_W +: DATA_W] + b_dout[grant*DATA_W +: DATA_W];
                c_ch      <= grant;
                remaining <= remaining - 1'b1;
                rr_ptr    <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
                out_valid <= 1'b1;
            end else if (c_write) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: if (ap_start) begin
                    ap_ready  <= 1'b1;
                    ap_idle   <= 1'b0;
                    remaining <= ap_len;
                    if (ap_len == '0) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                    end else begin
                        state   <= RUN;
                    end
                end
                RUN: if (remaining == '0) state <= DRAIN;
                DRAIN: if (!out_valid) begin
                    state   <= DONE;
                    ap_done <= 1'b1;
                end
                DONE: if (ap_continue) begin
                    state   <= IDLE;
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_STREAM_RR_SCHED_STATS_EN
    logic [31:0] stat_q [NUM_CH];

    // Counters restart with each job; out_valid is always 0 in IDLE so clear and count never collide.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
            stat_cnt <= '0;
        end else begin
            if (state == IDLE && ap_start && ap_len != '0) begin
                for (int i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
            end else if (c_write) begin
                stat_q[c_ch] <= stat_q[c_ch] + 32'd1;
            end
            stat_cnt <= stat_q[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_add_stream_rr_sched.sv
// Directed self-checking bench for add_stream_rr_sched (NUM_CH=4, DATA_W=32, default build).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_add_stream_rr_sched;

    logic         clk = 1'b0;
    logic         ap_rst;
    logic [127:0] a_dout, b_dout;
    logic [3:0]   a_empty_n, b_empty_n, a_read, b_read;
    logic [31:0]  c_din;
    logic [1:0]   c_ch;
    logic         c_full_n, c_write;
    logic         ap_start, ap_idle, ap_ready, ap_done, ap_continue;
    logic [15:0]  ap_len;

    int checks = 0;
    int errors = 0;

    add_stream_rr_sched #(.NUM_CH(4), .DATA_W(32), .LEN_W(16)) dut (
        .ap_clk(clk), .ap_rst(ap_rst),
        .a_dout(a_dout), .a_empty_n(a_empty_n), .a_read(a_read),
        .b_dout(b_dout), .b_empty_n(b_empty_n), .b_read(b_read),
        .c_din(c_din), .c_ch(c_ch), .c_full_n(c_full_n), .c_write(c_write),
        .ap_start(ap_start), .ap_len(ap_len), .ap_idle(ap_idle),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic ae, input logic be);
        a_dout[i*32 +: 32] = a;
        b_dout[i*32 +: 32] = b;
        a_empty_n[i] = ae;
        b_empty_n[i] = be;
    endtask

    task automatic clear_ch();
        for (int i = 0; i < 4; i++) set_ch(i, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Returns at the first falling edge after the job is accepted.
    task automatic start_job(input logic [15:0] len);
        ap_start = 1'b1;
        ap_len   = len;
        @(negedge clk);
        ap_start = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        for (int i = 0; i < 10 && !ap_done; i++) @(negedge clk);
        check({tag, "_done"}, 32'(ap_done), 32'd1);
        ap_continue = 1'b1;
        @(negedge clk);
        ap_continue = 1'b0;
        check({tag, "_idle"}, 32'(ap_idle), 32'd1);
        check({tag, "_done_clr"}, 32'(ap_done), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic wr, input logic [31:0] din,
                              input logic [1:0] ch, input logic [3:0] rd);
        check({tag, "_wr"}, 32'(c_write), 32'(wr));
        if (wr) begin
            check({tag, "_din"}, c_din, din);
            check({tag, "_ch"}, 32'(c_ch), 32'(ch));
        end
        check({tag, "_a_read"}, 32'(a_read), 32'(rd));
        check({tag, "_b_read"}, 32'(b_read), 32'(rd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ap_rst = 1'b1; a_dout = '0; b_dout = '0; a_empty_n = '0; b_empty_n = '0;
        c_full_n = 1'b1; ap_start = 1'b0; ap_len = '0; ap_continue = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_idle", 32'(ap_idle), 32'd1);
        check("rst_ready", 32'(ap_ready), 32'd0);
        check("rst_done", 32'(ap_done), 32'd0);
        expect_out("rst", 1'b0, 32'd0, 2'd0, 4'b0000);
        check("rst_din", c_din, 32'd0);
        check("rst_ch", 32'(c_ch), 32'd0);
        ap_rst = 1'b0;
        @(negedge clk);

        // All channels busy: strict rotation 0,1,2,3,... one write per cycle.
        for (int i = 0; i < 4; i++) set_ch(i, 32'h100 * (i + 1), 32'(i), 1'b1, 1'b1);
        start_job(16'd8);
        check("rr_ready", 32'(ap_ready), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            expect_out($sformatf("rr_c%0d", k), k >= 2,
                       32'h100 * ((k - 2) % 4 + 1) + 32'((k - 2) % 4),
                       2'((k - 2) % 4), (k <= 8) ? 4'(1 << ((k - 1) % 4)) : 4'b0000);
            @(negedge clk);
        end
        clear_ch();
        finish_job("rr");

        // Only ch2 fed 5+7; ap_continue outside DONE must be ignored.
        set_ch(2, 32'd5, 32'd7, 1'b1, 1'b1);
        start_job(16'd3);
        ap_continue = 1'b1;
        check("one_idle", 32'(ap_idle), 32'd0);
        expect_out("one_c1", 1'b0, 32'd0, 2'd0, 4'b0100);
        @(negedge clk);
        expect_out("one_c2", 1'b1, 32'd12, 2'd2, 4'b0100);
        @(negedge clk);
        expect_out("one_c3", 1'b1, 32'd12, 2'd2, 4'b0100);
        @(negedge clk);
        ap_continue = 1'b0;
        expect_out("one_c4", 1'b1, 32'd12, 2'd2, 4'b0000);
        @(negedge clk);
        expect_out("one_c5", 1'b0, 32'd0, 2'd0, 4'b0000);
        for (int i = 0; i < 10 && !ap_done; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("one_done_hold", 32'(ap_done), 32'd1);
            @(negedge clk);
        end
        clear_ch();
        finish_job("one");

        // Wrap-around add: carry out is dropped. rr_ptr is 3, so ch0 is found by wrapping.
        set_ch(0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
        start_job(16'd1);
        expect_out("wrap_c1", 1'b0, 32'd0, 2'd0, 4'b0001);
        @(negedge clk);
        expect_out("wrap_c2", 1'b1, 32'h0000_0001, 2'd0, 4'b0000);
        clear_ch();
        finish_job("wrap");

        // ch1 has a only: must be skipped, never partially popped.
        set_ch(1, 32'd9, 32'd0, 1'b1, 1'b0);
        set_ch(3, 32'd3, 32'd4, 1'b1, 1'b1);
        start_job(16'd2);
        expect_out("skip_c1", 1'b0, 32'd0, 2'd0, 4'b1000);
        @(negedge clk);
        expect_out("skip_c2", 1'b1, 32'd7, 2'd3, 4'b1000);
        @(negedge clk);
        expect_out("skip_c3", 1'b1, 32'd7, 2'd3, 4'b0000);
        clear_ch();
        finish_job("skip");

        // Back-pressure: 5 stalled cycles, then write and new read in the same cycle.
        set_ch(0, 32'd1, 32'd1, 1'b1, 1'b1);
        set_ch(1, 32'd2, 32'd2, 1'b1, 1'b1);
        start_job(16'd4);
        expect_out("stall_c1", 1'b0, 32'd0, 2'd0, 4'b0001);
        c_full_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wr", 32'(c_write), 32'd0);
            check("stall_din", c_din, 32'd2);
            check("stall_ch", 32'(c_ch), 32'd0);
            check("stall_read", 32'({a_read, b_read}), 32'd0);
        end
        c_full_n = 1'b1;
        #1;
        expect_out("stall_rel", 1'b1, 32'd2, 2'd0, 4'b0010);
        @(negedge clk);
        expect_out("stall_c7", 1'b1, 32'd4, 2'd1, 4'b0001);
        @(negedge clk);
        expect_out("stall_c8", 1'b1, 32'd2, 2'd0, 4'b0010);
        @(negedge clk);
        expect_out("stall_c9", 1'b1, 32'd4, 2'd1, 4'b0000);
        clear_ch();
        finish_job("stall");

        // Reset mid-job with a beat held in the output register.
        for (int i = 0; i < 4; i++) set_ch(i, 32'h100 * (i + 1), 32'(i), 1'b1, 1'b1);
        start_job(16'd8);
        expect_out("mrst_c1", 1'b0, 32'd0, 2'd0, 4'b0100);
        @(negedge clk);
        c_full_n = 1'b0;
        #1;
        check("mrst_held", 32'(c_ch), 32'd2);
        ap_rst = 1'b1;
        #1;
        expect_out("mrst_now", 1'b0, 32'd0, 2'd0, 4'b0000);
        check("mrst_din", c_din, 32'd0);
        check("mrst_ch", 32'(c_ch), 32'd0);
        check("mrst_idle", 32'(ap_idle), 32'd1);
        check("mrst_ready", 32'(ap_ready), 32'd0);
        check("mrst_done", 32'(ap_done), 32'd0);
        @(negedge clk);
        ap_rst = 1'b0;
        c_full_n = 1'b1;
        @(negedge clk);
        start_job(16'd2);
        expect_out("restart_c1", 1'b0, 32'd0, 2'd0, 4'b0001);
        @(negedge clk);
        expect_out("restart_c2", 1'b1, 32'h100, 2'd0, 4'b0010);
        @(negedge clk);
        expect_out("restart_c3", 1'b1, 32'h201, 2'd1, 4'b0000);
        clear_ch();
        finish_job("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
